// File: rtl/piso_shift_tx.sv
// Parallel-in / serial-out transmitter: accepts a WIDTH-bit word on a ready/load
// handshake and shifts it out one bit per clock, MSB- or LSB-first.
module piso_shift_tx #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             LEFT_RIGHT,
  output logic             READY,
  output logic             SO,
  output logic             SO_VALID,
  output logic             DONE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             dir, dir_n;

  // Outputs decode registered state only, so LOAD/D never reach SO combinationally.
  assign SO_VALID = (state == SHIFT);
  assign SO       = SO_VALID ? (dir ? sh[0] : sh[WIDTH-1]) : 1'b0;
  assign DONE     = SO_VALID && (cnt == LAST);
  assign READY    = (state == IDLE) || DONE;

  // NOTE: every next-state signal gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    dir_n   = dir;
    unique case (state)
      IDLE: begin
        if (LOAD) begin
          sh_n    = D;
          dir_n   = LEFT_RIGHT;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          sh_n  = dir ? {1'b0, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};
          cnt_n = cnt + 1'b1;
        end else if (LOAD) begin
          // Back-to-back reload: the next word's first bit follows with no gap.
          sh_n  = D;
          dir_n = LEFT_RIGHT;
          cnt_n = '0;
        end else begin
          sh_n    = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge C) begin
    if (RST) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
      dir   <= dir_n;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: directed scenarios plus a randomized
// loopback into a behavioural SIPO receiver.
module tb_piso_shift_tx;

  localparam int W = 8;

  logic         C = 1'b0;
  logic         RST = 1'b0;
  logic         LOAD = 1'b0;
  logic [W-1:0] D = '0;
  logic         LEFT_RIGHT = 1'b0;
  logic         READY, SO, SO_VALID, DONE;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural SIPO receiver: samples SO on the same edges while SO_VALID=1.
  logic [W-1:0] rx = '0;
  logic         rx_dir = 1'b0;

  piso_shift_tx #(.WIDTH(W)) dut (
    .C(C), .RST(RST), .LOAD(LOAD), .D(D), .LEFT_RIGHT(LEFT_RIGHT),
    .READY(READY), .SO(SO), .SO_VALID(SO_VALID), .DONE(DONE)
  );

  always #5 C = ~C;

  always @(posedge C)
    if (SO_VALID) rx <= rx_dir ? {SO, rx[W-1:1]} : {rx[W-2:0], SO};

  // Bit i (0 = first on the wire) of word d sent with order lr.
  function automatic logic exp_bit(input logic [W-1:0] d, input logic lr, input int i);
    return lr ? d[i] : d[W-1-i];
  endfunction

  // Expected {READY,SO,SO_VALID,DONE} while bit i of a word is on the wire.
  function automatic logic [3:0] exp_busy(input logic [W-1:0] d, input logic lr, input int i);
    return {i == W-1, exp_bit(d, lr, i), 1'b1, i == W-1};
  endfunction

  localparam logic [3:0] IDLE_OUT = 4'b1000;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; LOAD = 1'b1; D = W'($urandom); LEFT_RIGHT = 1'($urandom);
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if ({READY, SO, SO_VALID, DONE} !== IDLE_OUT) begin
        miscompares++;
        $display("FAIL reset[%0d]: got {rdy,so,vld,done}=%b want %b", k, {READY, SO, SO_VALID, DONE}, IDLE_OUT);
      end
    end
    RST = 1'b0; LOAD = 1'b0;
    tick();
    vectors++;
    if ({READY, SO, SO_VALID, DONE} !== IDLE_OUT) begin
      miscompares++;
      $display("FAIL reset_noload: got %b want %b", {READY, SO, SO_VALID, DONE}, IDLE_OUT);
    end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] w = 8'hA5;
    LOAD = 1'b1; D = w; LEFT_RIGHT = 1'b0;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < W; i++) begin
      D = W'($urandom); LEFT_RIGHT = 1'($urandom);
      vectors++;
      if ({READY, SO, SO_VALID, DONE} !== exp_busy(w, 1'b0, i)) begin
        miscompares++;
        $display("FAIL msb_first bit%0d: got %b want %b", i, {READY, SO, SO_VALID, DONE}, exp_busy(w, 1'b0, i));
      end
      tick();
    end
    vectors++;
    if ({READY, SO, SO_VALID, DONE} !== IDLE_OUT) begin
      miscompares++;
      $display("FAIL msb_first_idle: got %b want %b", {READY, SO, SO_VALID, DONE}, IDLE_OUT);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] words [2] = '{8'h81, 8'h0F};
    for (int n = 0; n < 2; n++) begin
      LOAD = 1'b1; D = words[n]; LEFT_RIGHT = 1'b1;
      tick();
      LOAD = 1'b0; LEFT_RIGHT = 1'b0;
      for (int i = 0; i < W; i++) begin
        vectors++;
        if ({READY, SO, SO_VALID, DONE} !== exp_busy(words[n], 1'b1, i)) begin
          miscompares++;
          $display("FAIL lsb_first w%0d bit%0d: got %b want %b", n, i, {READY, SO, SO_VALID, DONE}, exp_busy(words[n], 1'b1, i));
        end
        tick();
      end
      vectors++;
      if ({READY, SO, SO_VALID, DONE} !== IDLE_OUT) begin
        miscompares++;
        $display("FAIL lsb_first_idle w%0d: got %b want %b", n, {READY, SO, SO_VALID, DONE}, IDLE_OUT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w0 = 8'h3C, w1 = 8'hC3;
    LOAD = 1'b1; D = w0; LEFT_RIGHT = 1'b0;
    tick();
    for (int c = 0; c < 2*W; c++) begin
      logic [W-1:0] w  = (c < W) ? w0 : w1;
      logic         lr = (c < W) ? 1'b0 : 1'b1;
      if (c == W-1)        begin D = w1; LEFT_RIGHT = 1'b1; end
      else if (c == 2*W-1) LOAD = 1'b0;
      else                 begin D = W'($urandom); LEFT_RIGHT = 1'($urandom); end
      vectors++;
      if ({READY, SO, SO_VALID, DONE} !== exp_busy(w, lr, c % W)) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got %b want %b", c+1, {READY, SO, SO_VALID, DONE}, exp_busy(w, lr, c % W));
      end
      tick();
    end
    vectors++;
    if ({READY, SO, SO_VALID, DONE} !== IDLE_OUT) begin
      miscompares++;
      $display("FAIL back_to_back_idle: got %b want %b", {READY, SO, SO_VALID, DONE}, IDLE_OUT);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] w = 8'h01;
    LOAD = 1'b1; D = 8'hFF; LEFT_RIGHT = 1'b0;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({READY, SO, SO_VALID, DONE} !== exp_busy(8'hFF, 1'b0, i)) begin
        miscompares++;
        $display("FAIL abort_pre bit%0d: got %b want %b", i, {READY, SO, SO_VALID, DONE}, exp_busy(8'hFF, 1'b0, i));
      end
      if (i == 3) RST = 1'b1;
      tick();
    end
    RST = 1'b0;
    for (int k = 0; k < W; k++) begin
      vectors++;
      if ({READY, SO, SO_VALID, DONE} !== IDLE_OUT) begin
        miscompares++;
        $display("FAIL abort_quiet cyc%0d: got %b want %b", k, {READY, SO, SO_VALID, DONE}, IDLE_OUT);
      end
      tick();
    end
    LOAD = 1'b1; D = w; LEFT_RIGHT = 1'b0;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < W; i++) begin
      vectors++;
      if ({READY, SO, SO_VALID, DONE} !== exp_busy(w, 1'b0, i)) begin
        miscompares++;
        $display("FAIL abort_resend bit%0d: got %b want %b", i, {READY, SO, SO_VALID, DONE}, exp_busy(w, 1'b0, i));
      end
      tick();
    end
  endtask

  task automatic test_loopback();
    localparam int N = 256;
    logic [W-1:0] words [N];
    logic         dirs  [N];
    for (int k = 0; k < N; k++) begin
      words[k] = W'($urandom);
      dirs[k]  = (k % 2 == 0) ? 1'($urandom) : ~dirs[k-1];
    end
    rx_dir = dirs[0];
    LOAD = 1'b1; D = words[0]; LEFT_RIGHT = dirs[0];
    tick();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < W; i++) begin
        if (i == W-1) begin
          if (k == N-1) LOAD = 1'b0;
          else begin D = words[k+1]; LEFT_RIGHT = dirs[k+1]; end
        end else begin
          D = W'($urandom); LEFT_RIGHT = 1'($urandom);
        end
        vectors++;
        if ({READY, SO, SO_VALID, DONE} !== exp_busy(words[k], dirs[k], i)) begin
          miscompares++;
          $display("FAIL loopback w%0d bit%0d: got %b want %b", k, i, {READY, SO, SO_VALID, DONE}, exp_busy(words[k], dirs[k], i));
        end
        tick();
      end
      vectors++;
      if (rx !== words[k]) begin
        miscompares++;
        $display("FAIL loopback_rx w%0d dir%0d: got %h want %h", k, dirs[k], rx, words[k]);
      end
      if (k < N-1) rx_dir = dirs[k+1];
    end
    vectors++;
    if ({READY, SO, SO_VALID, DONE} !== IDLE_OUT) begin
      miscompares++;
      $display("FAIL loopback_idle: got %b want %b", {READY, SO, SO_VALID, DONE}, IDLE_OUT);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_abort();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
